// File: rtl/alu_res_station_if.sv
// Dispatch, CDB snoop and ALU issue signals of the ALU reservation station.
// The slave view belongs to the station; the master view belongs to its environment.
interface alu_res_station_if #(
    parameter int ROB_IDX_BITS = 5,
    parameter int OP_BITS      = 3
);
    logic                    flush;
    logic                    disp_valid;
    logic                    disp_rs1_ready;
    logic [31:0]             disp_rs1_data;
    logic                    disp_rs2_ready;
    logic [31:0]             disp_rs2_data;
    logic [ROB_IDX_BITS-1:0] disp_dest_rob;
    logic [OP_BITS-1:0]      disp_opcode;
    logic                    disp_rd_type;
    logic                    rs_ready;
    logic                    cdb_valid;
    logic [ROB_IDX_BITS-1:0] cdb_rob;
    logic [31:0]             cdb_data;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [31:0]             issue_a;
    logic [31:0]             issue_b;
    logic [OP_BITS-1:0]      issue_opcode;
    logic                    issue_rd_type;
    logic [ROB_IDX_BITS-1:0] issue_rob;

    modport slave (
        input  flush, disp_valid, disp_rs1_ready, disp_rs1_data, disp_rs2_ready,
               disp_rs2_data, disp_dest_rob, disp_opcode, disp_rd_type,
               cdb_valid, cdb_rob, cdb_data, issue_ready,
        output rs_ready, issue_valid, issue_a, issue_b, issue_opcode, issue_rd_type, issue_rob
    );

    modport master (
        output flush, disp_valid, disp_rs1_ready, disp_rs1_data, disp_rs2_ready,
               disp_rs2_data, disp_dest_rob, disp_opcode, disp_rd_type,
               cdb_valid, cdb_rob, cdb_data, issue_ready,
        input  rs_ready, issue_valid, issue_a, issue_b, issue_opcode, issue_rd_type, issue_rob
    );
endinterface

// File: rtl/alu_res_station.sv
// ALU reservation station: holds dispatched ops until both operands arrive via the
// CDB, then issues the oldest ready slot to the ALU over a valid/ready handshake.
module alu_rs_slot #(
    parameter int ROB_IDX_BITS = 5,
    parameter int OP_BITS      = 3,
    parameter int AGE_BITS     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc,
    input  logic                    clr,
    input  logic                    age_inc,
    input  logic                    d_a_rdy,
    input  logic [31:0]             d_a,
    input  logic                    d_b_rdy,
    input  logic [31:0]             d_b,
    input  logic [ROB_IDX_BITS-1:0] d_rob,
    input  logic [OP_BITS-1:0]      d_op,
    input  logic                    d_rd_type,
    input  logic                    cdb_valid,
    input  logic [ROB_IDX_BITS-1:0] cdb_rob,
    input  logic [31:0]             cdb_data,
    output logic                    valid,
    output logic                    ready,
    output logic [31:0]             a_val,
    output logic [31:0]             b_val,
    output logic [ROB_IDX_BITS-1:0] dest_rob,
    output logic [OP_BITS-1:0]      opcode,
    output logic                    rd_type,
    output logic [AGE_BITS-1:0]     age
);
    logic a_rdy, b_rdy;
    logic a_hit, b_hit, da_hit, db_hit;

    // Pending operands keep their tag in the low bits of the value field.
    assign a_hit  = cdb_valid && !a_rdy && (a_val[ROB_IDX_BITS-1:0] == cdb_rob);
    assign b_hit  = cdb_valid && !b_rdy && (b_val[ROB_IDX_BITS-1:0] == cdb_rob);
    assign da_hit = cdb_valid && !d_a_rdy && (d_a[ROB_IDX_BITS-1:0] == cdb_rob);
    assign db_hit = cdb_valid && !d_b_rdy && (d_b[ROB_IDX_BITS-1:0] == cdb_rob);
    assign ready  = valid && a_rdy && b_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            a_rdy    <= 1'b0;
            b_rdy    <= 1'b0;
            a_val    <= '0;
            b_val    <= '0;
            dest_rob <= '0;
            opcode   <= '0;
            rd_type  <= 1'b0;
            age      <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (alloc) begin
            valid    <= 1'b1;
            a_rdy    <= d_a_rdy || da_hit;
            a_val    <= da_hit ? cdb_data : d_a;
            b_rdy    <= d_b_rdy || db_hit;
            b_val    <= db_hit ? cdb_data : d_b;
            dest_rob <= d_rob;
            opcode   <= d_op;
            rd_type  <= d_rd_type;
            age      <= '0;
        end else if (valid) begin
            if (clr) valid <= 1'b0;
            if (a_hit) begin
                a_rdy <= 1'b1;
                a_val <= cdb_data;
            end
            if (b_hit) begin
                b_rdy <= 1'b1;
                b_val <= cdb_data;
            end
            if (age_inc && age != '1) age <= age + 1'b1;
        end
    end
endmodule

module alu_res_station #(
    parameter int NUM_ENTRIES  = 4,
    parameter int ROB_IDX_BITS = 5,
    parameter int OP_BITS      = 3
) (
    input logic              clk,
    input logic              rst,
    alu_res_station_if.slave bus
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam int AW = IW + 1;

    logic [NUM_ENTRIES-1:0]                   valid, ready, alloc, clr, rd_type;
    logic [NUM_ENTRIES-1:0][31:0]             a_val, b_val;
    logic [NUM_ENTRIES-1:0][ROB_IDX_BITS-1:0] dest_rob;
    logic [NUM_ENTRIES-1:0][OP_BITS-1:0]      opcode;
    logic [NUM_ENTRIES-1:0][AW-1:0]           age;
    logic [IW-1:0]                            free_idx, sel;
    logic [AW-1:0]                            best_age;
    logic                                     any_rdy, rs_ready, issue_valid, disp_fire, issue_fire;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) free_idx = IW'(i);
    end

    // Oldest ready slot wins; ages are unique among valid slots.
    always_comb begin
        sel      = '0;
        any_rdy  = 1'b0;
        best_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ready[i] && (!any_rdy || age[i] > best_age)) begin
                any_rdy  = 1'b1;
                best_age = age[i];
                sel      = IW'(i);
            end
        end
    end

    assign rs_ready    = ~&valid;
    assign issue_valid = any_rdy && !bus.flush;
    assign disp_fire   = bus.disp_valid && rs_ready && !bus.flush;
    assign issue_fire  = issue_valid && bus.issue_ready;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_slot
        assign alloc[g] = disp_fire && (free_idx == IW'(g));
        assign clr[g]   = issue_fire && (sel == IW'(g));

        alu_rs_slot #(
            .ROB_IDX_BITS(ROB_IDX_BITS),
            .OP_BITS     (OP_BITS),
            .AGE_BITS    (AW)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (bus.flush),
            .alloc    (alloc[g]),
            .clr      (clr[g]),
            .age_inc  (disp_fire),
            .d_a_rdy  (bus.disp_rs1_ready),
            .d_a      (bus.disp_rs1_data),
            .d_b_rdy  (bus.disp_rs2_ready),
            .d_b      (bus.disp_rs2_data),
            .d_rob    (bus.disp_dest_rob),
            .d_op     (bus.disp_opcode),
            .d_rd_type(bus.disp_rd_type),
            .cdb_valid(bus.cdb_valid),
            .cdb_rob  (bus.cdb_rob),
            .cdb_data (bus.cdb_data),
            .valid    (valid[g]),
            .ready    (ready[g]),
            .a_val    (a_val[g]),
            .b_val    (b_val[g]),
            .dest_rob (dest_rob[g]),
            .opcode   (opcode[g]),
            .rd_type  (rd_type[g]),
            .age      (age[g])
        );
    end

    assign bus.rs_ready      = rs_ready;
    assign bus.issue_valid   = issue_valid;
    assign bus.issue_a       = a_val[sel];
    assign bus.issue_b       = b_val[sel];
    assign bus.issue_opcode  = opcode[sel];
    assign bus.issue_rd_type = rd_type[sel];
    assign bus.issue_rob     = dest_rob[sel];
endmodule

// File: tb/tb_alu_res_station.sv
// Scenario bench for alu_res_station: each task drives one scenario and checks
// timing inline; issued ops are matched in order against a scoreboard queue.
module tb_alu_res_station;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        rd;
        logic [4:0]  rob;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    sb_t  exp_q[$];

    alu_res_station_if #(.ROB_IDX_BITS(5), .OP_BITS(3)) bus ();

    alu_res_station #(.NUM_ENTRIES(4), .ROB_IDX_BITS(5), .OP_BITS(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic sb_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                               input logic rd, input logic [4:0] rob);
        sb_t s;
        s.a = a; s.b = b; s.op = op; s.rd = rd; s.rob = rob;
        return s;
    endfunction

    // Called at the negative edge: retire any handshake against the scoreboard, then advance.
    task automatic step();
        sb_t got, exp;
        if (bus.issue_valid && bus.issue_ready) begin
            got = mk(bus.issue_a, bus.issue_b, bus.issue_opcode, bus.issue_rd_type, bus.issue_rob);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: issued rob=%0d a=%h, expected nothing", got.rob, got.a);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_issue: got a=%h b=%h op=%0d rd=%0b rob=%0d, expected a=%h b=%h op=%0d rd=%0b rob=%0d",
                             got.a, got.b, got.op, got.rd, got.rob, exp.a, exp.b, exp.op, exp.rd, exp.rob);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic disp(input logic a_rdy, input logic [31:0] a, input logic b_rdy, input logic [31:0] b,
                        input logic [4:0] rob, input logic [2:0] op, input logic rd);
        bus.disp_valid     = 1'b1;
        bus.disp_rs1_ready = a_rdy;
        bus.disp_rs1_data  = a;
        bus.disp_rs2_ready = b_rdy;
        bus.disp_rs2_data  = b;
        bus.disp_dest_rob  = rob;
        bus.disp_opcode    = op;
        bus.disp_rd_type   = rd;
    endtask

    task automatic bcast(input logic [4:0] rob, input logic [31:0] data);
        bus.cdb_valid = 1'b1;
        bus.cdb_rob   = rob;
        bus.cdb_data  = data;
    endtask

    task automatic test_reset();
        idle();
        bus.issue_ready = 1'b0;
        disp(1'b1, 32'd1, 1'b1, 32'd2, 5'd1, 3'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.rs_ready !== 1'b1) begin errors++; $display("FAIL reset_rs_ready: got %b, expected 1", bus.rs_ready); end
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b, expected 0", bus.issue_valid); end
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_no_entry: got %b, expected 0", bus.issue_valid); end
        step();
    endtask

    task automatic test_basic();
        bus.issue_ready = 1'b1;
        disp(1'b1, 32'd5, 1'b1, 32'd7, 5'd3, 3'd0, 1'b1);
        exp_q.push_back(mk(32'd5, 32'd7, 3'd0, 1'b1, 5'd3));
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_same_cycle: got %b, expected 0", bus.issue_valid); end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_a !== 32'd5 || bus.issue_b !== 32'd7 || bus.issue_rob !== 5'd3) begin
            errors++;
            $display("FAIL basic_issue: got v=%b a=%0d b=%0d rob=%0d, expected v=1 a=5 b=7 rob=3",
                     bus.issue_valid, bus.issue_a, bus.issue_b, bus.issue_rob);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b, expected 0", bus.issue_valid); end
        step();
    endtask

    task automatic test_wakeup();
        bus.issue_ready = 1'b1;
        disp(1'b0, 32'hFFFF_FF09, 1'b1, 32'd1, 5'd10, 3'd1, 1'b0);
        exp_q.push_back(mk(32'h100, 32'd1, 3'd1, 1'b0, 5'd10));
        for (int c = 0; c < 3; c++) begin
            if (c == 1) idle();
            if (c == 2) bcast(5'd9, 32'h100);
            @(negedge clk);
            checks++;
            if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait_c%0d: got %b, expected 0", c, bus.issue_valid); end
            step();
        end
        idle();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_a !== 32'h100) begin
            errors++;
            $display("FAIL wake_issue: got v=%b a=%h, expected v=1 a=00000100", bus.issue_valid, bus.issue_a);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL wake_drained: got %b, expected 0", bus.issue_valid); end
        step();
    endtask

    task automatic test_age_order();
        bus.issue_ready = 1'b0;
        disp(1'b0, 32'd4, 1'b1, 32'd2, 5'd11, 3'd2, 1'b0);
        step();
        disp(1'b1, 32'd3, 1'b1, 32'd4, 5'd12, 3'd3, 1'b1);
        exp_q.push_back(mk(32'd3, 32'd4, 3'd3, 1'b1, 5'd12));
        exp_q.push_back(mk(32'h44, 32'd2, 3'd2, 1'b0, 5'd11));
        step();
        idle();
        bcast(5'd4, 32'h44);
        bus.issue_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd12) begin
            errors++;
            $display("FAIL age_young_ready_first: got v=%b rob=%0d, expected v=1 rob=12", bus.issue_valid, bus.issue_rob);
        end
        step();
        idle();
        bus.issue_ready = 1'b0;
        disp(1'b1, 32'd8, 1'b1, 32'd9, 5'd13, 3'd4, 1'b1);
        exp_q.push_back(mk(32'd8, 32'd9, 3'd4, 1'b1, 5'd13));
        @(negedge clk);
        checks++;
        if (bus.issue_rob !== 5'd11) begin errors++; $display("FAIL age_woken_x: got rob=%0d, expected 11", bus.issue_rob); end
        step();
        idle();
        bus.issue_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd11) begin
            errors++;
            $display("FAIL age_older_wins: got v=%b rob=%0d, expected v=1 rob=11", bus.issue_valid, bus.issue_rob);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.issue_rob !== 5'd13) begin errors++; $display("FAIL age_then_z: got rob=%0d, expected 13", bus.issue_rob); end
        step();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL age_drained: got %b, expected 0", bus.issue_valid); end
        step();
    endtask

    task automatic test_full();
        bus.issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(1'b0, 32'hABCD_0000 | (32'd20 + 32'(i)), 1'b1, 32'(i), 5'(20 + i), 3'(i), i[0]);
            @(negedge clk);
            checks++;
            if (bus.rs_ready !== 1'b1) begin errors++; $display("FAIL full_fill_%0d: rs_ready %b, expected 1", i, bus.rs_ready); end
            step();
        end
        disp(1'b1, 32'd1, 1'b1, 32'd1, 5'd30, 3'd5, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.rs_ready !== 1'b0) begin errors++; $display("FAIL full_rs_ready: got %b, expected 0", bus.rs_ready); end
        step();
        idle();
        bcast(5'd21, 32'h21);
        exp_q.push_back(mk(32'h21, 32'd1, 3'd1, 1'b1, 5'd21));
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL full_dropped: got issue_valid %b, expected 0", bus.issue_valid); end
        step();
        idle();
        bus.issue_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.rs_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_issue: got v=%b rs_ready=%b, expected v=1 rs_ready=0", bus.issue_valid, bus.rs_ready);
        end
        step();
        bus.issue_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rs_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_freed: got rs_ready=%b v=%b, expected rs_ready=1 v=0", bus.rs_ready, bus.issue_valid);
        end
        step();
    endtask

    // Runs on the three pending slots (tags 20, 22, 23) left behind by test_full.
    task automatic test_flush();
        bcast(5'd20, 32'h20);
        step();
        idle();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_rob !== 5'd20) begin
            errors++;
            $display("FAIL flush_pre: got v=%b rob=%0d, expected v=1 rob=20", bus.issue_valid, bus.issue_rob);
        end
        step();
        bus.flush = 1'b1;
        bus.issue_ready = 1'b1;
        disp(1'b1, 32'd6, 1'b1, 32'd6, 5'd29, 3'd6, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle: got issue_valid %b, expected 0", bus.issue_valid); end
        step();
        idle();
        bcast(5'd22, 32'h22);
        @(negedge clk);
        checks++;
        if (bus.rs_ready !== 1'b1 || bus.issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: got rs_ready=%b v=%b, expected rs_ready=1 v=0", bus.rs_ready, bus.issue_valid);
        end
        step();
        bcast(5'd23, 32'h23);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_c%0d: got %b, expected 0", c, bus.issue_valid); end
            step();
            idle();
        end
    endtask

    task automatic test_bypass();
        bus.issue_ready = 1'b1;
        disp(1'b0, 32'h5555_0006, 1'b1, 32'h5, 5'd7, 3'd7, 1'b1);
        bcast(5'd6, 32'hAB);
        exp_q.push_back(mk(32'hAB, 32'h5, 3'd7, 1'b1, 5'd7));
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_same_cycle: got %b, expected 0", bus.issue_valid); end
        step();
        idle();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b1 || bus.issue_a !== 32'hAB) begin
            errors++;
            $display("FAIL bypass_issue: got v=%b a=%h, expected v=1 a=000000ab", bus.issue_valid, bus.issue_a);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_drained: got %b, expected 0", bus.issue_valid); end
        step();
    endtask

    initial begin
        bus.cdb_rob        = '0;
        bus.cdb_data       = '0;
        test_reset();
        test_basic();
        test_wakeup();
        test_age_order();
        test_full();
        test_flush();
        test_bypass();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected issues never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
